fir_data_ring: RTL
==================

Name: fir_data_ring

Overview:
- Parametrised data-SRAM controller for the FIR engine.
- Replaces the shift-register history with a circular buffer held directly in data SRAM.
- Clears the SRAM on start, accepts one AXI-Stream sample at a time and writes it at the ring head, then issues TAP_NUM reads newest→oldest, paired with coefficient indices, to the MAC.
- Sits between the ss_* input stream, the data SRAM and the tap/MAC datapath.

Parameters:
- pADDR_WIDTH, 12, SRAM byte-address width
- pDATA_WIDTH, 32, sample width
- TAP_NUM, 11, filter taps = ring depth (2..1024)
- IDX_WIDTH, 10, width of ring index / tap index (≥ clog2(TAP_NUM))
- CNT_WIDTH, 16, processed-sample counter width

Ports:
- axis_clk  in  1  clock
- axis_rst  in  1  asynchronous active-high reset
- ap_start  in  1  one-cycle start pulse; honoured only in IDLE
- ss_tvalid  in  1  stream valid
- ss_tdata  in  pDATA_WIDTH  sample
- ss_tlast  in  1  final sample of the stream
- ss_tready  out  1  stream ready
- data_WE  out  4  SRAM byte write enables
- data_EN  out  1  SRAM enable
- data_Di  out  pDATA_WIDTH  SRAM write data
- data_A  out  pADDR_WIDTH  SRAM byte address (index*4)
- tap_idx  out  IDX_WIDTH  coefficient index paired with the current read
- mac_valid  out  1  data_Do valid for the MAC this cycle
- mac_first  out  1  with mac_valid: first product of a sample (clear accumulator)
- mac_last  out  1  with mac_valid: last product of a sample
- out_last  out  1  with mac_last: this sample carried ss_tlast
- done  out  1  one-cycle pulse after the tlast sample completes
- sample_cnt  out  CNT_WIDTH  samples accepted since ap_start

Behaviour:
- Reset (async, active-high):
  - state=IDLE, head=TAP_NUM-1, all counters 0.
  - All outputs 0, including ss_tready, data_EN, data_WE, mac_* and done.
  - Reset mid-operation abandons the sample; no partial SRAM write is guaranteed.
- Output timing:
  - SRAM outputs, ss_tready and tap_idx are decoded from registered state/counters.
  - mac_valid, mac_first, mac_last and out_last are registered one cycle behind the read, matching the SRAM's 1-cycle read latency.
- IDLE:
  - All outputs inactive.
  - ap_start → CLEAR; clear c=0, sample_cnt=0, head=TAP_NUM-1.
  - ap_start outside IDLE is ignored.
- CLEAR, c=0..TAP_NUM-1:
  - EN=1, WE=4'hF, A=4c, Di=0.
  - Transition to WAIT_IN after c=TAP_NUM-1; exactly TAP_NUM write cycles.
- WAIT_IN:
  - ss_tready=1.
  - On ss_tvalid (same cycle): EN=1, WE=4'hF, A=4·nh, Di=ss_tdata, where nh = (head==TAP_NUM-1)?0:head+1.
  - Register head←nh, last_r←ss_tlast, sample_cnt+1 (wraps at 2^CNT_WIDTH); → READ with k=0.
  - Without ss_tvalid: EN=0; state unchanged.
- READ, k=0..TAP_NUM-1:
  - EN=1, WE=0, tap_idx=k.
  - A = 4·((head≥k) ? head-k : head+TAP_NUM-k).
  - After k=TAP_NUM-1 → FLUSH.
  - ss_tready=0 throughout.
- FLUSH (1 cycle):
  - EN=0; delivers the final mac_valid.
  - Then → DONE if last_r, else WAIT_IN.
- DONE:
  - done=1 for one cycle → IDLE.
  - head and SRAM contents are retained, but the next ap_start re-clears them.
- MAC strobes:
  - mac_valid is high for exactly TAP_NUM consecutive cycles per sample.
  - mac_first is on the first of these; mac_last and out_last (=last_r) on the last.
- Throughput: 1 + TAP_NUM + 1 cycles per sample, given ss_tvalid held high.
- Boundary conditions:
  - Ring wrap is at TAP_NUM-1→0.
  - The first sample lands at index 0; before wrap, unwritten history reads 0 from the CLEAR phase.
  - ss_tlast on the first sample: full TAP_NUM reads, then DONE.
  - ss_tvalid while not in WAIT_IN: not accepted, since ss_tready=0.

Decomposition:
- fir_pkg holds:
  - state encoding: IDLE, CLEAR, WAIT_IN, READ, FLUSH, DONE
  - BYTES_PER_WORD=4
  - address-shift constant 2
- Sub-module fir_ring_index (combinational modular next-head and head-minus-k arithmetic, parametrised by TAP_NUM and IDX_WIDTH), instantiated twice.

Test Plan:
1. Reset, then ap_start with TAP_NUM=11 → 11 consecutive writes, Di=0, A=0,4,…,40; then ss_tready=1.
2. Accept samples 1 and 2 → sample 1 written at A=0, then reads A=0,40,36,…,4 with tap_idx 0..10. Sample 2 written at A=4, then read first at A=4, second at A=0. mac_valid high for 11 cycles per sample, first/last strobes correct.
3. Stream 12 samples x=1..12 → 12th written at A=0 (wrap); its reads start A=0,40,36… Golden-model y with h=1..11 matches MAC output.
4. ss_tlast on sample 3 → out_last with that sample's mac_last; done pulses 1 cycle after FLUSH; state IDLE; ss_tready=0; sample_cnt=3.
5. axis_rst asserted during READ k=5 → next cycle all outputs 0. Subsequent ap_start re-clears and restarts at A=0; ap_start pulsed mid-READ is ignored.
6. TAP_NUM=4 build, 6 samples with ss_tvalid gaps → writes at A=0,4,8,12,0,4. No acceptance while ss_tready=0; sample 6 read order A=4,0,12,8.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR data-ring controller: controller state
// encoding and the word/byte addressing constants used to turn a ring index
// into an SRAM byte address.
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_READ    = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5
    } fir_state_e;

    localparam int BYTES_PER_WORD = 4;
    // Byte address = word index << ADDR_SHIFT
    localparam int ADDR_SHIFT = $clog2(BYTES_PER_WORD);

    localparam logic [BYTES_PER_WORD-1:0] WE_ALL  = 4'hF;
    localparam logic [BYTES_PER_WORD-1:0] WE_NONE = 4'h0;

endpackage

// File: rtl/fir_data_ring_if.sv
// -----------------------------------------------------------------------------
// fir_data_ring_if
// AXI-Stream style sample input to the FIR data ring.
//   ss_tvalid : source has a sample
//   ss_tdata  : sample value
//   ss_tlast  : final sample of the stream
//   ss_tready : ring controller can take the sample this cycle
// master = sample source, slave = ring controller.
// -----------------------------------------------------------------------------
interface fir_data_ring_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;

    modport master (
        output ss_tvalid,
        output ss_tdata,
        output ss_tlast,
        input  ss_tready
    );

    modport slave (
        input  ss_tvalid,
        input  ss_tdata,
        input  ss_tlast,
        output ss_tready
    );
endinterface

// File: rtl/fir_ring_index.sv
// -----------------------------------------------------------------------------
// fir_ring_index
// Combinational modular addition on the ring: idx_o = (base_i + delta_i) mod
// TAP_NUM, valid for base_i in [0, TAP_NUM-1] and delta_i in [0, TAP_NUM].
//   delta_i = 1           -> next head (wraps TAP_NUM-1 -> 0)
//   delta_i = TAP_NUM - k -> head - k modulo the ring depth
// Ports:
//   base_i  : ring index
//   delta_i : offset, one bit wider than the index so TAP_NUM itself fits
//   idx_o   : resulting ring index
// -----------------------------------------------------------------------------
module fir_ring_index #(
    parameter int TAP_NUM   = 11,
    parameter int IDX_WIDTH = 10
) (
    input  logic [IDX_WIDTH-1:0] base_i,
    input  logic [IDX_WIDTH:0]   delta_i,
    output logic [IDX_WIDTH-1:0] idx_o
);
    localparam logic [IDX_WIDTH:0] DEPTH = (IDX_WIDTH+1)'(TAP_NUM);

    logic [IDX_WIDTH:0] sum_s;

    // Single conditional subtract suffices since the sum never reaches 2*TAP_NUM
    always_comb begin
        sum_s = {1'b0, base_i} + delta_i;
        if (sum_s >= DEPTH) begin
            idx_o = IDX_WIDTH'(sum_s - DEPTH);
        end else begin
            idx_o = sum_s[IDX_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/fir_data_ring.sv
// -----------------------------------------------------------------------------
// fir_data_ring
// Data-SRAM controller for the FIR engine. The sample history lives in SRAM
// as a circular buffer of TAP_NUM words. On ap_start the buffer is zeroed;
// each accepted sample is written at the next ring head and then the whole
// history is read newest -> oldest, each read paired with its coefficient
// index, feeding the MAC.
// Ports:
//   axis_clk, axis_rst : clock, asynchronous active-high reset
//   ap_start           : start pulse, honoured only when idle
//   ss                 : sample input stream (slave side)
//   data_WE/EN/Di/A    : data SRAM port (byte address = index*4)
//   tap_idx            : coefficient index of the current read
//   mac_valid/first/last, out_last : MAC strobes, one cycle behind the reads
//   done               : one-cycle pulse after the tlast sample completes
//   sample_cnt         : samples accepted since ap_start
// -----------------------------------------------------------------------------
module fir_data_ring
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int TAP_NUM     = 11,
    parameter int IDX_WIDTH   = 10,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    fir_data_ring_if.slave         ss,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [IDX_WIDTH-1:0]   tap_idx,
    output logic                   mac_valid,
    output logic                   mac_first,
    output logic                   mac_last,
    output logic                   out_last,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   sample_cnt
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TAP_NUM - 1);
    localparam logic [IDX_WIDTH:0]   DEPTH_W  = (IDX_WIDTH+1)'(TAP_NUM);
    localparam logic [IDX_WIDTH:0]   ONE_W    = (IDX_WIDTH+1)'(1);

    fir_state_e             state_q, state_d;
    logic [IDX_WIDTH-1:0]   head_q, head_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;          // clear index c / read index k
    logic                   last_q, last_d;
    logic [CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic                   mac_valid_q, mac_valid_d;
    logic                   mac_first_q, mac_first_d;
    logic                   mac_last_q, mac_last_d;
    logic                   out_last_q, out_last_d;

    logic [IDX_WIDTH-1:0]   next_head_s;
    logic [IDX_WIDTH-1:0]   rd_idx_s;
    logic [IDX_WIDTH:0]     rd_delta_s;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IDX_WIDTH-1:0] idx);
        word_addr = pADDR_WIDTH'(idx) << ADDR_SHIFT;
    endfunction

    // head - k as head + (TAP_NUM - k); k = 0 gives delta TAP_NUM and lands back on head
    assign rd_delta_s = DEPTH_W - {1'b0, idx_q};

    fir_ring_index #(
        .TAP_NUM   (TAP_NUM),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_next_head (
        .base_i  (head_q),
        .delta_i (ONE_W),
        .idx_o   (next_head_s)
    );

    fir_ring_index #(
        .TAP_NUM   (TAP_NUM),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_read_idx (
        .base_i  (head_q),
        .delta_i (rd_delta_s),
        .idx_o   (rd_idx_s)
    );

    // State, ring pointers, counters and the delayed MAC strobes
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q      <= ST_IDLE;
            head_q       <= LAST_IDX;
            idx_q        <= '0;
            last_q       <= 1'b0;
            sample_cnt_q <= '0;
            mac_valid_q  <= 1'b0;
            mac_first_q  <= 1'b0;
            mac_last_q   <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            sample_cnt_q <= sample_cnt_d;
            mac_valid_q  <= mac_valid_d;
            mac_first_q  <= mac_first_d;
            mac_last_q   <= mac_last_d;
            out_last_q   <= out_last_d;
        end
    end

    // Next-state logic and SRAM/stream decode from the registered state
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        idx_d        = idx_q;
        last_d       = last_q;
        sample_cnt_d = sample_cnt_q;
        mac_valid_d  = 1'b0;
        mac_first_d  = 1'b0;
        mac_last_d   = 1'b0;
        out_last_d   = 1'b0;
        ss.ss_tready = 1'b0;
        data_EN      = 1'b0;
        data_WE      = WE_NONE;
        data_Di      = '0;
        data_A       = '0;
        tap_idx      = '0;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d      = ST_CLEAR;
                    idx_d        = '0;
                    sample_cnt_d = '0;
                    head_d       = LAST_IDX;
                    last_d       = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                data_EN = 1'b1;
                data_WE = WE_ALL;
                data_A  = word_addr(idx_q);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_WAIT_IN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end
            end

            ST_WAIT_IN: begin
                ss.ss_tready = 1'b1;
                if (ss.ss_tvalid) begin
                    data_EN      = 1'b1;
                    data_WE      = WE_ALL;
                    data_A       = word_addr(next_head_s);
                    data_Di      = ss.ss_tdata;
                    head_d       = next_head_s;
                    last_d       = ss.ss_tlast;
                    sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
                    idx_d        = '0;
                    state_d      = ST_READ;
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end

            ST_READ: begin
                data_EN     = 1'b1;
                tap_idx     = idx_q;
                data_A      = word_addr(rd_idx_s);
                // Strobes describe this read but appear next cycle with its data
                mac_valid_d = 1'b1;
                mac_first_d = (idx_q == '0);
                mac_last_d  = (idx_q == LAST_IDX);
                out_last_d  = (idx_q == LAST_IDX) && last_q;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FLUSH;
                end else begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end
            end

            ST_FLUSH: begin
                if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mac_valid  = mac_valid_q;
    assign mac_first  = mac_first_q;
    assign mac_last   = mac_last_q;
    assign out_last   = out_last_q;
    assign sample_cnt = sample_cnt_q;

endmodule
